// File: rtl/glyph_frame_sequencer_pkg.sv
// Shared types and constants for the glyph frame sequencer.
package glyph_seq_pkg;

  typedef enum logic [1:0] {
    StIntro,
    StRun,
    StPaused,
    StSettle
  } state_t;

  localparam int unsigned FRAME_W = 10;
  localparam logic [FRAME_W-1:0] FRAME_MAX = 10'd1023;
  localparam int unsigned SETTLE_FRAMES_DEF = 4;

endpackage

// File: rtl/glyph_frame_sequencer_edge.sv
// Vsync leading-edge detector: tick is high in the cycle vsync first reaches its asserted level.
module vsync_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic tick
);

  logic r_vsync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsync <= ACTIVE_LOW;
    end else begin
      r_vsync <= vsync;
    end
  end

  // XOR with the polarity maps the raw level onto "asserted".
  assign tick = (vsync ^ ACTIVE_LOW) & ~(r_vsync ^ ACTIVE_LOW);

endmodule

// File: rtl/glyph_frame_sequencer.sv
// Animation frame sequencer: intro count, run, pause/step and post-mode-change settle blanking.
// Optional PALETTE_CYCLE_EN rotates pal_id with frame[9:8] while running.
module glyph_frame_sequencer
  import glyph_seq_pkg::*;
#(
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned SETTLE_FRAMES    = SETTLE_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic [1:0]         mode,
  input  logic               pause,
  input  logic               step,
  input  logic [1:0]         pal_sel,
  output logic [FRAME_W-1:0] frame,
  output logic               rst_drop,
  output logic               blank,
  output logic [1:0]         pal_id,
  output logic               frame_tick
);

  state_t             r_state;
  logic [FRAME_W-1:0] r_frame;
  logic               r_drop;
  logic               r_blank;
  logic               r_tick;
  logic               r_ret_run;
  logic               r_pend;
  logic               r_step;
  logic [1:0]         r_mode;
  logic [3:0]         r_cnt;

  logic w_tick;
  logic w_mode_chg;
  logic w_step_rise;
  logic w_adv;
  logic w_adv_run;
  logic w_wrap;

  vsync_edge_detect #(
    .ACTIVE_LOW (VSYNC_ACTIVE_LOW)
  ) u_edge (
    .clk   (clk),
    .reset (reset),
    .vsync (vsync),
    .tick  (w_tick)
  );

  assign w_mode_chg  = (mode != r_mode);
  assign w_step_rise = step & ~r_step;
  assign w_wrap      = (r_frame == FRAME_MAX);
  assign w_adv_run   = (r_state == StRun) || ((r_state == StPaused) && r_ret_run);

  // Frame advances on a tick when running, or when a step is pending while paused.
  assign w_adv = !w_mode_chg && w_tick &&
                 ((((r_state == StIntro) || (r_state == StRun)) && !pause) ||
                  ((r_state == StPaused) && pause && r_pend));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIntro;
      r_frame   <= '0;
      r_drop    <= 1'b0;
      r_blank   <= 1'b0;
      r_tick    <= 1'b0;
      r_ret_run <= 1'b0;
      r_pend    <= 1'b0;
      r_step    <= 1'b0;
      r_mode    <= mode;
      r_cnt     <= '0;
    end else begin
      r_step <= step;
      r_mode <= mode;
      r_tick <= w_adv;
      if (w_mode_chg) begin
        r_state <= StSettle;
        r_cnt   <= 4'(SETTLE_FRAMES);
        r_blank <= 1'b1;
        r_pend  <= 1'b0;
      end else begin
        if (w_adv) begin
          r_frame <= r_frame + 1'b1;
          if (!w_adv_run && w_wrap) begin
            r_drop    <= 1'b1;
            r_ret_run <= 1'b1;
          end
        end
        unique case (r_state)
          StIntro, StRun: begin
            if (pause) begin
              r_state   <= StPaused;
              r_ret_run <= (r_state == StRun);
            end else if (w_adv && w_wrap && (r_state == StIntro)) begin
              r_state <= StRun;
            end
          end
          StPaused: begin
            if (!pause) begin
              r_state <= r_ret_run ? StRun : StIntro;
              r_pend  <= 1'b0;
            end else if (w_adv) begin
              r_pend <= 1'b0;
            end else if (w_step_rise) begin
              r_pend <= 1'b1;
            end
          end
          StSettle: begin
            if (w_tick) begin
              r_cnt <= r_cnt - 1'b1;
              if (r_cnt == 4'd1) begin
                r_state <= StIntro;
                r_frame <= '0;
                r_drop  <= 1'b0;
                r_blank <= 1'b0;
              end
            end
          end
          default: r_state <= StIntro;
        endcase
      end
    end
  end

  assign frame      = r_frame;
  assign rst_drop   = r_drop;
  assign blank      = r_blank;
  assign frame_tick = r_tick;

`ifdef PALETTE_CYCLE_EN
  assign pal_id = w_adv_run ? (pal_sel + r_frame[9:8]) : pal_sel;
`else
  assign pal_id = pal_sel;
`endif

endmodule

// File: tb/tb_glyph_frame_sequencer.sv
// Scoreboard bench: stimulus pushes expected {rst_drop, frame} per advance; monitor checks on frame_tick.
module tb_glyph_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic [1:0] mode;
  logic       pause;
  logic       step;
  logic [1:0] pal_sel;
  logic [9:0] frame;
  logic       rst_drop;
  logic       blank;
  logic [1:0] pal_id;
  logic       frame_tick;

  int n_vec = 0;
  int n_err = 0;
  logic [10:0] sb[$];

  glyph_frame_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .mode       (mode),
    .pause      (pause),
    .step       (step),
    .pal_sel    (pal_sel),
    .frame      (frame),
    .rst_drop   (rst_drop),
    .blank      (blank),
    .pal_id     (pal_id),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Monitor: every frame_tick must match the oldest expected advance.
  always @(negedge clk) begin
    if (frame_tick === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_tick: frame=%0d rst_drop=%0d with nothing expected",
                 frame, rst_drop);
      end else begin
        logic [10:0] e;
        e = sb.pop_front();
        if ({rst_drop, frame} !== e) begin
          n_err++;
          $display("FAIL advance: got frame=%0d rst_drop=%0d, expected frame=%0d rst_drop=%0d",
                   frame, rst_drop, e[9:0], e[10]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One vsync pulse (active low); optionally expect an advance to {ed, ef}.
  task automatic tick(input bit push, input logic [9:0] ef, input logic ed);
    vsync = 1'b0;
    if (push) sb.push_back({ed, ef});
    cyc(1);
    vsync = 1'b1;
    cyc(1);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b1; mode = 2'd0; pause = 1'b0; step = 1'b0; pal_sel = 2'd2;
    #2;
    chk("reset_frame", 32'(frame), 0);
    chk("reset_drop", 32'(rst_drop), 0);
    chk("reset_blank", 32'(blank), 0);
    chk("reset_tick", 32'(frame_tick), 0);
    chk("reset_pal", 32'(pal_id), 2);
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // Intro: 1024 ticks, last one wraps and finishes the drop.
    for (int i = 0; i < 1024; i++) tick(1'b1, 10'((i + 1) % 1024), (i == 1023));
    chk("intro_done_drop", 32'(rst_drop), 1);
    chk("intro_done_frame", 32'(frame), 0);

    // Run to 100, then pause/step behaviour.
    for (int i = 0; i < 100; i++) tick(1'b1, 10'(i + 1), 1'b1);
    pause = 1'b1;
    cyc(1);
    repeat (5) tick(1'b0, 10'd0, 1'b0);
    chk("paused_hold", 32'(frame), 100);
    pal_sel = 2'd1;
    chk("paused_pal", 32'(pal_id), 1);
    pulse_step();
    tick(1'b1, 10'd101, 1'b1);
    chk("step_adv", 32'(frame), 101);
    pulse_step();
    pulse_step();
    tick(1'b1, 10'd102, 1'b1);
    tick(1'b0, 10'd0, 1'b0);
    chk("step_one_deep", 32'(frame), 102);
    pulse_step();
    pause = 1'b0;
    cyc(1);
    pause = 1'b1;
    cyc(1);
    tick(1'b0, 10'd0, 1'b0);
    chk("pend_cleared", 32'(frame), 102);
    pause = 1'b0;
    cyc(1);

    // Frame 256 in RUN for the palette check.
    for (int i = 102; i < 256; i++) tick(1'b1, 10'(i + 1), 1'b1);
    pal_sel = 2'd3;
    #1;
`ifdef PALETTE_CYCLE_EN
    chk("pal_cycle", 32'(pal_id), 0);
`else
    chk("pal_cycle", 32'(pal_id), 3);
`endif
    for (int i = 256; i < 500; i++) tick(1'b1, 10'(i + 1), 1'b1);

    // Mode change at 500: four blanked ticks, then back to intro.
    mode = 2'd1;
    cyc(1);
    chk("settle_blank", 32'(blank), 1);
    chk("settle_hold", 32'(frame), 500);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 10'd0, 1'b0);
      chk("settle_blank_n", 32'(blank), 1);
      chk("settle_hold_n", 32'(frame), 500);
    end
    tick(1'b0, 10'd0, 1'b0);
    chk("settle_exit_frame", 32'(frame), 0);
    chk("settle_exit_drop", 32'(rst_drop), 0);
    chk("settle_exit_blank", 32'(blank), 0);
    tick(1'b1, 10'd1, 1'b0);

    // Mode change coincident with tick and pause: settle wins.
    vsync = 1'b0; pause = 1'b1; mode = 2'd2;
    cyc(1);
    chk("prio_blank", 32'(blank), 1);
    chk("prio_frame", 32'(frame), 1);
    vsync = 1'b1; pause = 1'b0;
    cyc(1);
    tick(1'b0, 10'd0, 1'b0);
    tick(1'b0, 10'd0, 1'b0);
    mode = 2'd3;
    cyc(1);
    for (int i = 0; i < 3; i++) tick(1'b0, 10'd0, 1'b0);
    chk("reload_blank", 32'(blank), 1);
    tick(1'b0, 10'd0, 1'b0);
    chk("reload_exit", 32'(blank), 0);

    // Async reset mid-settle, two cycles after a tick.
    for (int i = 0; i < 3; i++) tick(1'b1, 10'(i + 1), 1'b0);
    mode = 2'd0;
    cyc(1);
    tick(1'b0, 10'd0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_frame", 32'(frame), 0);
    chk("arst_blank", 32'(blank), 0);
    chk("arst_drop", 32'(rst_drop), 0);
    chk("arst_tick", 32'(frame_tick), 0);
    chk("arst_pal", 32'(pal_id), 3);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    tick(1'b1, 10'd1, 1'b0);

    cyc(4);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/glyph_frame_sequencer.md
GLYPH_FRAME_SEQUENCER -- requirements
Module: glyph_frame_sequencer

Interface
REQ-001 SHALL have parameter VSYNC_ACTIVE_LOW, default 1, meaning 1 = vsync pulse is low-asserted.
REQ-002 SHALL have parameter SETTLE_FRAMES, default 4 (range 1..15), meaning frames held blanked after a mode change.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port vsync, input, 1 bit: the timing generator's vsync, synchronous to clk.
REQ-006 SHALL have port mode, input, 2 bits: the video mode select also fed to the timing generator.
REQ-007 SHALL have port pause, input, 1 bit: level; freezes animation.
REQ-008 SHALL have port step, input, 1 bit: single-frame advance while paused.
REQ-009 SHALL have port pal_sel, input, 2 bits: user palette select.
REQ-010 SHALL have port frame, output, 10 bits: animation frame counter.
REQ-011 SHALL have port rst_drop, output, 1 bit: intro-drop sequence finished.
REQ-012 SHALL have port blank, output, 1 bit: forces RGB to zero.
REQ-013 SHALL have port pal_id, output, 2 bits: palette id for the palette ROM.
REQ-014 SHALL have port frame_tick, output, 1 bit: one-cycle pulse on each frame advance.

Function
REQ-015 SHALL detect a tick as the clk cycle where vsync goes from deasserted to asserted level (polarity per VSYNC_ACTIVE_LOW), using one registered copy of vsync.
REQ-016 SHALL implement states INTRO, RUN, PAUSED and SETTLE.
REQ-017 In INTRO, each tick SHALL increment frame; a tick at frame==1023 SHALL wrap frame to 0, set rst_drop=1 and enter RUN, all in the same cycle.
REQ-018 In RUN, each tick SHALL increment frame modulo 1024; rst_drop SHALL stay 1.
REQ-019 In INTRO or RUN with pause=1, the FSM SHALL enter PAUSED and record the return state (INTRO/RUN); a tick in that same cycle SHALL be ignored.
REQ-020 In PAUSED, a rising edge of step SHALL set a one-deep pending flag; the next tick SHALL consume the flag and advance frame exactly as the return state would, including the INTRO->rst_drop transition; extra step edges before that tick SHALL be dropped.
REQ-021 In PAUSED with pause=0, the FSM SHALL return to the recorded state on the next cycle and clear any pending step.
REQ-022 A change of mode versus its registered copy SHALL, from any state, enter SETTLE, load the settle counter with SETTLE_FRAMES, assert blank, and hold frame; this has priority over pause and tick.
REQ-023 In SETTLE, each tick SHALL decrement the counter; on the tick where the counter reaches 0, the FSM SHALL set frame=0, rst_drop=0, blank=0 and enter INTRO.
REQ-024 A further mode change during SETTLE SHALL reload the counter.
REQ-025 frame_tick SHALL be 1 exactly in the cycle after frame changes value, except on reset and SETTLE exit.
REQ-026 blank SHALL be 1 only in SETTLE.

Reset
REQ-027 On reset, the block SHALL set state=INTRO, frame=0, rst_drop=0, blank=0, frame_tick=0, pal_id=pal_sel-driven value, step flag=0, the mode copy to the current mode, and the vsync copy to the deasserted level.
REQ-028 Reset asserted mid-frame or mid-SETTLE SHALL take effect immediately and asynchronously, with no pending tick surviving.

Configuration
REQ-029 With PALETTE_CYCLE_EN defined, the block SHALL drive pal_id = (pal_sel + frame[9:8]) mod 4 in RUN and PAUSED-from-RUN, and pal_sel otherwise.
REQ-030 Without PALETTE_CYCLE_EN, the block SHALL drive pal_id = pal_sel combinationally in all states.

Structure
REQ-031 Package glyph_seq_pkg SHALL hold the state enum, FRAME_W=10, FRAME_MAX=1023 and the default SETTLE_FRAMES.
REQ-032 The edge detector SHALL be sub-module vsync_edge_detect (ports clk, reset, vsync, tick; parameter ACTIVE_LOW).

Verification
REQ-033 Reset release, then 1024 ticks -> frame counts 0..1023; tick 1024 gives frame=0 and rst_drop=1 with state RUN.
REQ-034 RUN at frame=100, pause=1 then 5 ticks -> frame stays 100; one step pulse then 1 tick -> frame=101 with a single frame_tick.
REQ-035 RUN at frame=500, mode 0->1 -> blank=1 for 4 ticks with frame=500 held; on the 4th tick frame=0, rst_drop=0, blank=0, INTRO.
REQ-036 Mode change coincident with a tick and pause=1 -> SETTLE entered, frame unchanged.
REQ-037 PALETTE_CYCLE_EN defined, pal_sel=3, frame=256 in RUN -> pal_id=0; undefined -> pal_id=3.
REQ-038 Reset asserted 2 cycles after a tick during SETTLE -> all outputs reach their reset values without a clk edge.
